// File: rtl/trans_ascii_pkg.sv
// -----------------------------------------------------------------------------
// trans_ascii_pkg
// Shared definitions for the multi-channel ASCII frame formatter:
//   - state_e      : formatter FSM encoding
//   - ASC_*        : ASCII constants used when building a frame
//   - label_char() : two-character label per channel (8'h00 = no character)
//   - unit_char()  : one-character unit per channel
//   - label_entry(): first position inside a channel's label, skipping empty
//                    label characters (falls through to the colon if both
//                    label characters are empty)
//   - pow10()      : elaboration-time power of ten for digit saturation
// -----------------------------------------------------------------------------
package trans_ascii_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LEAD  = 4'd1,
        ST_LABEL = 4'd2,
        ST_COLON = 4'd3,
        ST_DIGIT = 4'd4,
        ST_UNIT  = 4'd5,
        ST_SEP   = 4'd6,
        ST_CR    = 4'd7,
        ST_LF    = 4'd8
    } state_e;

    localparam logic [7:0] ASC_NUL   = 8'h00;
    localparam logic [7:0] ASC_SPACE = 8'h20;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_COMMA = 8'h2C;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_ZERO  = 8'h30;

    // Position in the frame where a channel's printed text starts.
    typedef struct packed {
        state_e     st;
        logic [1:0] sub;
    } label_pos_t;

    // Label table: ch0 "RH", ch1 "T", ch2 "V", ch3 "I".
    function automatic logic [7:0] label_char(input logic [1:0] ch, input logic sub);
        logic [7:0] c;
        case ({ch, sub})
            3'b000:  c = 8'h52; // 'R'
            3'b001:  c = 8'h48; // 'H'
            3'b010:  c = 8'h54; // 'T'
            3'b011:  c = 8'h00;
            3'b100:  c = 8'h56; // 'V'
            3'b101:  c = 8'h00;
            3'b110:  c = 8'h49; // 'I'
            3'b111:  c = 8'h00;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // Unit table: ch0 '%', ch1 'C', ch2 'V', ch3 'A'.
    function automatic logic [7:0] unit_char(input logic [1:0] ch);
        logic [7:0] c;
        case (ch)
            2'd0:    c = 8'h25; // '%'
            2'd1:    c = 8'h43; // 'C'
            2'd2:    c = 8'h56; // 'V'
            2'd3:    c = 8'h41; // 'A'
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // Empty label characters consume no cycle, so entry skips straight past them.
    function automatic label_pos_t label_entry(input logic [1:0] ch);
        label_pos_t p;
        if (label_char(ch, 1'b0) != ASC_NUL) begin
            p.st  = ST_LABEL;
            p.sub = 2'd0;
        end else if (label_char(ch, 1'b1) != ASC_NUL) begin
            p.st  = ST_LABEL;
            p.sub = 2'd1;
        end else begin
            p.st  = ST_COLON;
            p.sub = 2'd0;
        end
        return p;
    endfunction

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/trans_ascii_multi_if.sv
// -----------------------------------------------------------------------------
// trans_ascii_multi_if
// Character stream handshake between the formatter and its consumer
// (typically a UART TX FIFO).
//   ascii       : current character
//   ascii_valid : ascii holds a character for the consumer
//   ascii_ready : consumer accepts ascii (transfer when valid && ready)
// Modports: master = character producer, slave = character consumer.
// -----------------------------------------------------------------------------
interface trans_ascii_multi_if;
    logic [7:0] ascii;
    logic       ascii_valid;
    logic       ascii_ready;

    modport master (output ascii, output ascii_valid, input ascii_ready);
    modport slave  (input ascii, input ascii_valid, output ascii_ready);
endinterface

// File: rtl/ascii_digit_sel.sv
// -----------------------------------------------------------------------------
// ascii_digit_sel
// Combinational: picks one decimal digit of a channel value as ASCII.
//   value : unsigned channel value (DATA_W bits)
//   idx   : digit index, 0 = most significant of DIGITS printed digits
//   ascii : "0".."9"; values >= 10^DIGITS saturate to all "9"
// -----------------------------------------------------------------------------
module ascii_digit_sel
    import trans_ascii_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] value,
    input  logic [1:0]        idx,
    output logic [7:0]        ascii
);

    localparam logic [31:0] MAX_VAL  = 32'(pow10(DIGITS) - 1);
    localparam logic [1:0]  LAST_POS = 2'(DIGITS - 1);

    logic [31:0] val_s;
    logic [31:0] sat_s;
    logic [3:0]  d0_s;
    logic [3:0]  d1_s;
    logic [3:0]  d2_s;
    logic [1:0]  pos_s;
    logic [3:0]  dig_s;

    // Saturate, split into decimal digits and select the requested one.
    always_comb begin
        val_s = 32'(value);
        if (val_s > MAX_VAL) begin
            sat_s = MAX_VAL;
        end else begin
            sat_s = val_s;
        end
        d0_s  = 4'(sat_s % 32'd10);
        d1_s  = 4'((sat_s / 32'd10) % 32'd10);
        d2_s  = 4'((sat_s / 32'd100) % 32'd10);
        // idx counts from the most significant printed digit.
        pos_s = LAST_POS - idx;
        case (pos_s)
            2'd0:    dig_s = d0_s;
            2'd1:    dig_s = d1_s;
            2'd2:    dig_s = d2_s;
            default: dig_s = d0_s;
        endcase
        ascii = ASC_ZERO + {4'h0, dig_s};
    end

endmodule

// File: rtl/trans_ascii_multi.sv
// -----------------------------------------------------------------------------
// trans_ascii_multi
// Formats NUM_CH channel values into one ASCII frame:
//   " " { label ":" DIGITS-digits unit } separated by "," then terminator.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   ch_data    : NUM_CH*DATA_W channel values, channel 0 in the LSBs
//   start      : one-cycle frame request, accepted only when idle
//   tx         : character stream (master modport: ascii/ascii_valid out,
//                ascii_ready in)
//   busy       : frame in progress (state != IDLE)
//   overrun    : one-cycle pulse when a start is dropped because busy
// Build option: define TRANS_ASCII_CRLF_EN to end frames with CR LF instead
// of LF alone.
// -----------------------------------------------------------------------------
module trans_ascii_multi
    import trans_ascii_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIGITS = 2,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     start,
    trans_ascii_multi_if.master      tx,
    output logic                     busy,
    output logic                     overrun
);

    localparam logic [1:0] LAST_CH  = 2'(NUM_CH - 1);
    localparam logic [1:0] LAST_DIG = 2'(DIGITS - 1);

    state_e                   state_r;
    state_e                   state_next_s;
    logic [1:0]               ch_r;
    logic [1:0]               ch_next_s;
    logic [1:0]               sub_r;
    logic [1:0]               sub_next_s;
    logic [NUM_CH*DATA_W-1:0] snap_r;
    logic [7:0]               ascii_r;
    logic                     valid_r;
    logic                     busy_r;
    logic                     overrun_r;
    logic                     xfer_s;
    logic                     advance_s;
    label_pos_t               entry_s;
    logic [DATA_W-1:0]        ch_val_s;
    logic [7:0]               digit_char_s;
    logic [7:0]               char_s;

    assign tx.ascii       = ascii_r;
    assign tx.ascii_valid = valid_r;
    assign busy           = busy_r;
    assign overrun        = overrun_r;

    // Decide whether the FSM moves this cycle: start in IDLE, a transfer otherwise.
    always_comb begin
        xfer_s = valid_r & tx.ascii_ready;
        if (state_r == ST_IDLE) begin
            advance_s = start;
        end else begin
            advance_s = xfer_s;
        end
    end

    // Next-state logic: the state always names the character being presented.
    always_comb begin
        state_next_s = state_r;
        ch_next_s    = ch_r;
        sub_next_s   = sub_r;
        entry_s      = label_entry(ch_r);
        if (advance_s) begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_LEAD;
                    ch_next_s    = 2'd0;
                    sub_next_s   = 2'd0;
                end
                ST_LEAD: begin
                    entry_s      = label_entry(2'd0);
                    state_next_s = entry_s.st;
                    ch_next_s    = 2'd0;
                    sub_next_s   = entry_s.sub;
                end
                ST_LABEL: begin
                    if ((sub_r == 2'd0) && (label_char(ch_r, 1'b1) != ASC_NUL)) begin
                        state_next_s = ST_LABEL;
                        sub_next_s   = 2'd1;
                    end else begin
                        state_next_s = ST_COLON;
                        sub_next_s   = 2'd0;
                    end
                end
                ST_COLON: begin
                    state_next_s = ST_DIGIT;
                    sub_next_s   = 2'd0;
                end
                ST_DIGIT: begin
                    if (sub_r == LAST_DIG) begin
                        state_next_s = ST_UNIT;
                        sub_next_s   = 2'd0;
                    end else begin
                        state_next_s = ST_DIGIT;
                        sub_next_s   = sub_r + 2'd1;
                    end
                end
                ST_UNIT: begin
                    if (ch_r == LAST_CH) begin
`ifdef TRANS_ASCII_CRLF_EN
                        state_next_s = ST_CR;
`else
                        state_next_s = ST_LF;
`endif
                    end else begin
                        state_next_s = ST_SEP;
                    end
                    sub_next_s = 2'd0;
                end
                ST_SEP: begin
                    entry_s      = label_entry(ch_r + 2'd1);
                    state_next_s = entry_s.st;
                    ch_next_s    = ch_r + 2'd1;
                    sub_next_s   = entry_s.sub;
                end
                ST_CR: begin
                    state_next_s = ST_LF;
                    sub_next_s   = 2'd0;
                end
                ST_LF: begin
                    state_next_s = ST_IDLE;
                    ch_next_s    = 2'd0;
                    sub_next_s   = 2'd0;
                end
                default: begin
                    state_next_s = ST_IDLE;
                    ch_next_s    = 2'd0;
                    sub_next_s   = 2'd0;
                end
            endcase
        end else begin
            state_next_s = state_r;
            ch_next_s    = ch_r;
            sub_next_s   = sub_r;
        end
    end

    // Select the snapshot value of the channel the next character belongs to.
    always_comb begin
        ch_val_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_val_s = (ch_next_s == 2'(i)) ? snap_r[i*DATA_W +: DATA_W] : ch_val_s;
        end
    end

    ascii_digit_sel #(
        .DIGITS (DIGITS),
        .DATA_W (DATA_W)
    ) u_digit_sel (
        .value (ch_val_s),
        .idx   (sub_next_s),
        .ascii (digit_char_s)
    );

    // Character that the next state presents.
    always_comb begin
        case (state_next_s)
            ST_IDLE:  char_s = ASC_NUL;
            ST_LEAD:  char_s = ASC_SPACE;
            ST_LABEL: char_s = label_char(ch_next_s, sub_next_s[0]);
            ST_COLON: char_s = ASC_COLON;
            ST_DIGIT: char_s = digit_char_s;
            ST_UNIT:  char_s = unit_char(ch_next_s);
            ST_SEP:   char_s = ASC_COMMA;
            ST_CR:    char_s = ASC_CR;
            ST_LF:    char_s = ASC_LF;
            default:  char_s = ASC_NUL;
        endcase
    end

    // State, counters, snapshot and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ch_r      <= 2'd0;
            sub_r     <= 2'd0;
            snap_r    <= '0;
            ascii_r   <= 8'h00;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ch_r    <= ch_next_s;
            sub_r   <= sub_next_s;
            // Snapshot only on the accepted start so the frame is self-consistent.
            if ((state_r == ST_IDLE) && start) begin
                snap_r <= ch_data;
            end
            // ascii/valid hold while the consumer stalls.
            if (advance_s) begin
                ascii_r <= char_s;
                valid_r <= (state_next_s != ST_IDLE);
            end
            busy_r    <= (state_next_s != ST_IDLE);
            // Still busy during the final LF transfer, so a start there is dropped too.
            overrun_r <= start & (state_r != ST_IDLE);
        end
    end

endmodule

// File: doc/trans_ascii_multi.md
TRANS_ASCII_MULTI -- requirements
Module: trans_ascii_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning channels per frame (1..4).
REQ-002 SHALL have parameter DIGITS, default 2, meaning decimal digits printed per channel (1..3).
REQ-003 SHALL have parameter DATA_W, default 8, meaning unsigned width of each channel value (4..10).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port ch_data  input  NUM_CH*DATA_W  channel values, channel 0 in the LSBs.
REQ-007 SHALL have port start  input  1  one-cycle request to format and emit one frame.
REQ-008 SHALL have port ascii  output  8  current character.
REQ-009 SHALL have port ascii_valid  output  1  ascii holds a character for the consumer.
REQ-010 SHALL have port ascii_ready  input  1  consumer (UART TX FIFO not-full) accepts ascii.
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when start is dropped.

Function
REQ-013 SHALL emit the frame: " ", then per channel i = 0..NUM_CH-1: label chars, ":", DIGITS digits, unit char; "," between channels; then the terminator.
REQ-014 SHALL take labels (2 chars) and unit (1 char) per channel from the package table; a label char of 8'h00 SHALL be skipped (no character, no cycle).
REQ-015 SHALL emit digits most-significant first as "0"+d, leading zeros printed.
REQ-016 SHALL saturate: a value >= 10^DIGITS SHALL print all "9".
REQ-017 SHALL capture ch_data into an internal snapshot on the accepted start; later ch_data changes SHALL NOT affect the frame.
REQ-018 SHALL implement states IDLE, LEAD, LABEL, COLON, DIGIT, UNIT, SEP, CR, LF, with channel index and digit/label sub-index counters.
REQ-019 SHALL accept start only in IDLE; ascii_valid SHALL rise on the cycle after the accepted start with ascii = " ".
REQ-020 SHALL register ascii and ascii_valid; a character SHALL transfer only in a cycle with ascii_valid and ascii_ready both high.
REQ-021 SHALL hold ascii stable and ascii_valid high while ascii_ready is low; the next character SHALL be presented in the cycle after the transfer (one character per cycle at full throughput).
REQ-022 SHALL return to IDLE and drop ascii_valid in the cycle after the final LF transfer; busy SHALL equal (state != IDLE).
REQ-023 SHALL pulse overrun for one cycle on start while busy, including in the cycle of the final LF transfer, and drop that request.
REQ-024 SHALL emit no SEP after the last channel; with NUM_CH=1 no "," SHALL appear.

Reset
REQ-025 SHALL, on rst_n low, immediately force state IDLE, counters 0, snapshot 0, ascii 8'h00, ascii_valid 0, busy 0, overrun 0.
REQ-026 SHALL abandon a partial frame on reset; after release the next start SHALL emit a complete frame from " ".

Configuration
REQ-027 SHALL honour macro TRANS_ASCII_CRLF_EN: when defined, the terminator SHALL be 8'h0D then 8'h0A (CR state used); when undefined, the terminator SHALL be 8'h0A only and CR SHALL be unreachable.

Structure
REQ-028 SHALL place the state encoding, the label/unit table (4 channels), and the ASCII constants (space, colon, comma, CR, LF, "0") in package trans_ascii_pkg.
REQ-029 SHALL use one sub-module, ascii_digit_sel: combinational, value + digit index -> saturated ASCII digit.

Verification
REQ-030 SHALL cover the default configuration with ready held high: values 45/23 -> " RH:45%,T:23C" then 8'h0A, 14 characters in 14 consecutive cycles.
REQ-031 SHALL cover backpressure: ready toggled 1/0 with a random pattern -> identical character sequence, ascii stable whenever valid is high and ready is low.
REQ-032 SHALL cover saturation with DIGITS=2: value 150 -> "99"; DIGITS=3, value 7 -> "007".
REQ-033 SHALL cover overrun: start again in the 5th frame cycle -> overrun is one pulse and the frame is unchanged; ch_data changed mid-frame -> snapshot values printed.
REQ-034 SHALL cover the CRLF build: with TRANS_ASCII_CRLF_EN defined -> frame ends 8'h0D, 8'h0A, 15 characters total.
REQ-035 SHALL cover reset mid-frame: rst_n low during the digits -> all outputs 0 asynchronously, and the next start emits a full frame.
